// File: rtl/pic_pkg.sv
// Shared types, constants and vector helpers for the PIC acknowledge/in-service logic.
// Helpers work on MAX_IRQ-wide vectors; callers pass the active width n.
package pic_pkg;

    localparam int unsigned MAX_IRQ   = 32;
    localparam int unsigned MAX_LVL_W = 5;
    localparam logic [7:0]  CALL_OPCODE = 8'hCD;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK1 = 2'd1,
        ACK2 = 2'd2,
        ACK3 = 2'd3
    } ack_state_t;

    function automatic logic [MAX_IRQ-1:0] lvl2onehot(input logic [MAX_LVL_W-1:0] lvl);
        logic [MAX_IRQ-1:0] r;
        r = '0;
        r[lvl] = 1'b1;
        return r;
    endfunction

    // Bit i of the result is bit (i+amt) mod n of v; bits at and above n are zero.
    function automatic logic [MAX_IRQ-1:0] rotate_right(input logic [MAX_IRQ-1:0] v,
                                                        input int unsigned amt,
                                                        input int unsigned n);
        logic [MAX_IRQ-1:0]   r;
        logic [MAX_LVL_W-1:0] src;
        r = '0;
        for (int unsigned i = 0; i < MAX_IRQ; i++) begin
            if (i < n) begin
                src = MAX_LVL_W'((i + amt) % n);
                r[MAX_LVL_W'(i)] = v[src];
            end else begin
                r[MAX_LVL_W'(i)] = 1'b0;
            end
        end
        return r;
    endfunction

    function automatic logic [MAX_IRQ-1:0] rotate_left(input logic [MAX_IRQ-1:0] v,
                                                       input int unsigned amt,
                                                       input int unsigned n);
        logic [MAX_IRQ-1:0]   r;
        logic [MAX_LVL_W-1:0] dst;
        r = '0;
        for (int unsigned i = 0; i < MAX_IRQ; i++) begin
            if (i < n) begin
                dst = MAX_LVL_W'((i + amt) % n);
                r[dst] = v[MAX_LVL_W'(i)];
            end else begin
                r[MAX_LVL_W'(i)] = r[MAX_LVL_W'(i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Rotating priority resolver: highest priority is level priority_bottom+1, decreasing cyclically.
module pic_priority_resolver
    import pic_pkg::*;
#(
    parameter int unsigned NUM_IRQ = 8,
    parameter int unsigned LVL_W   = $clog2(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0] vec,
    input  logic [LVL_W-1:0]   priority_bottom,
    output logic [NUM_IRQ-1:0] onehot,
    output logic [LVL_W-1:0]   level,
    output logic               valid
);

    logic [MAX_IRQ-1:0]   wide_s;
    logic [MAX_IRQ-1:0]   rot_s;
    logic [MAX_IRQ-1:0]   pick_s;
    logic [MAX_IRQ-1:0]   back_s;
    logic [MAX_LVL_W-1:0] idx_s;
    logic [31:0]          amt_s;
    logic [31:0]          lvl_sum_s;
    logic                 found_s;
    logic                 unused_s;

    // Rotate so the highest-priority level sits at bit 0, pick the lowest set bit, rotate back.
    always_comb begin
        wide_s = '0;
        wide_s[NUM_IRQ-1:0] = vec;
        amt_s = 32'(priority_bottom) + 32'd1;
        rot_s = rotate_right(wide_s, amt_s, NUM_IRQ);
        found_s = 1'b0;
        idx_s = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (!found_s && rot_s[MAX_LVL_W'(i)]) begin
                found_s = 1'b1;
                idx_s = MAX_LVL_W'(i);
            end else begin
                found_s = found_s;
            end
        end
        if (found_s) begin
            pick_s = lvl2onehot(idx_s);
        end else begin
            pick_s = '0;
        end
        back_s = rotate_left(pick_s, amt_s, NUM_IRQ);
        lvl_sum_s = (32'(idx_s) + amt_s) % 32'(NUM_IRQ);
        onehot = back_s[NUM_IRQ-1:0];
        level = LVL_W'(lvl_sum_s);
        valid = found_s;
    end

    assign unused_s = ^{rot_s, back_s, lvl_sum_s, amt_s};

endmodule

// File: rtl/pic_ack_sequencer.sv
// PIC interrupt-acknowledge sequencer: INT generation, 8080/8086 INTA cycles, ISR ownership and EOI.
module pic_ack_sequencer
    import pic_pkg::*;
#(
    parameter int unsigned NUM_IRQ = 8,
    parameter int unsigned LVL_W   = $clog2(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               init,
    input  logic               cfg_upm,
    input  logic               cfg_aeoi,
    input  logic               cfg_auto_rotate,
    input  logic [7:0]         cfg_vec_lo,
    input  logic [7:0]         cfg_vec_hi,
    input  logic [NUM_IRQ-1:0] irq_req,
    input  logic               inta_n,
    input  logic               eoi_cmd,
    input  logic               eoi_specific,
    input  logic [LVL_W-1:0]   eoi_level,
    input  logic               eoi_rotate,
    output logic               int_out,
    output logic [7:0]         data_out,
    output logic               data_out_en,
    output logic [NUM_IRQ-1:0] isr,
    output logic [NUM_IRQ-1:0] clear_req,
    output logic [LVL_W-1:0]   priority_bottom
);

    localparam logic [LVL_W-1:0] TOP_LVL = LVL_W'(NUM_IRQ - 1);

    ack_state_t           state_r, state_next_s;
    logic                 inta_prev_r, upm_r, upm_next_s;
    logic [LVL_W-1:0]     ack_lvl_r, ack_next_s, bottom_r, bottom_next_s;
    logic [NUM_IRQ-1:0]   isr_r, isr_next_s, isr_set_s, clear_r, clear_next_s;
    logic [NUM_IRQ-1:0]   eoi_clr_s, aeoi_clr_s, req_hot_s, isr_hot_s;
    logic [LVL_W-1:0]     req_lvl_s, isr_lvl_s, eoi_lvl_s, req_rank_s, isr_rank_s;
    logic                 req_valid_s, isr_valid_s, eoi_done_s, end_seq_s;
    logic                 fall_s, rise_s, data_en_r, data_en_next_s, unused_s;
    logic [7:0]           data_r, data_next_s, vector_s;
    logic [MAX_IRQ-1:0]   eoi_wide_s, ack_wide_s;

    pic_priority_resolver #(.NUM_IRQ(NUM_IRQ), .LVL_W(LVL_W)) u_req_res (
        .vec(irq_req), .priority_bottom(bottom_r),
        .onehot(req_hot_s), .level(req_lvl_s), .valid(req_valid_s)
    );

    pic_priority_resolver #(.NUM_IRQ(NUM_IRQ), .LVL_W(LVL_W)) u_isr_res (
        .vec(isr_r), .priority_bottom(bottom_r),
        .onehot(isr_hot_s), .level(isr_lvl_s), .valid(isr_valid_s)
    );

    assign fall_s   = inta_prev_r & ~inta_n;
    assign rise_s   = ~inta_prev_r & inta_n;
    assign vector_s = {cfg_vec_lo[7:LVL_W], ack_lvl_r};

    // INTA sequence next state and the acknowledge byte to present while INTA is low.
    always_comb begin
        state_next_s   = state_r;
        upm_next_s     = upm_r;
        ack_next_s     = ack_lvl_r;
        isr_set_s      = '0;
        clear_next_s   = '0;
        data_next_s    = 8'h00;
        data_en_next_s = 1'b0;
        end_seq_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (fall_s) begin
                    state_next_s = ACK1;
                    upm_next_s   = cfg_upm;
                    if (req_valid_s) begin
                        ack_next_s   = req_lvl_s;
                        isr_set_s    = req_hot_s;
                        clear_next_s = req_hot_s;
                    end else begin
                        ack_next_s = TOP_LVL;
                    end
                    if (!cfg_upm) begin
                        data_next_s    = CALL_OPCODE;
                        data_en_next_s = 1'b1;
                    end else begin
                        data_en_next_s = 1'b0;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACK1: begin
                if (rise_s) begin
                    state_next_s = ACK2;
                end else if (!upm_r && !inta_n) begin
                    data_next_s    = CALL_OPCODE;
                    data_en_next_s = 1'b1;
                end else begin
                    data_en_next_s = 1'b0;
                end
            end
            ACK2: begin
                if (rise_s) begin
                    if (upm_r) begin
                        state_next_s = IDLE;
                        end_seq_s    = 1'b1;
                    end else begin
                        state_next_s = ACK3;
                    end
                end else if (!inta_n) begin
                    data_next_s    = vector_s;
                    data_en_next_s = 1'b1;
                end else begin
                    data_en_next_s = 1'b0;
                end
            end
            ACK3: begin
                if (rise_s) begin
                    state_next_s = IDLE;
                    end_seq_s    = 1'b1;
                end else if (!inta_n) begin
                    data_next_s    = cfg_vec_hi;
                    data_en_next_s = 1'b1;
                end else begin
                    data_en_next_s = 1'b0;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // EOI/AEOI clear masks and rotation; an explicit EOI rotation beats the automatic one.
    always_comb begin
        eoi_wide_s = lvl2onehot(MAX_LVL_W'(eoi_level));
        ack_wide_s = lvl2onehot(MAX_LVL_W'(ack_lvl_r));
        eoi_clr_s  = '0;
        eoi_lvl_s  = eoi_level;
        eoi_done_s = 1'b0;
        if (eoi_cmd && eoi_specific) begin
            eoi_clr_s  = eoi_wide_s[NUM_IRQ-1:0];
            eoi_done_s = 1'b1;
        end else if (eoi_cmd && isr_valid_s) begin
            eoi_clr_s  = isr_hot_s;
            eoi_lvl_s  = isr_lvl_s;
            eoi_done_s = 1'b1;
        end else begin
            eoi_done_s = 1'b0;
        end
        if (end_seq_s && cfg_aeoi) begin
            aeoi_clr_s = ack_wide_s[NUM_IRQ-1:0];
        end else begin
            aeoi_clr_s = '0;
        end
        isr_next_s = (isr_r | isr_set_s) & ~(eoi_clr_s | aeoi_clr_s);
        if (eoi_done_s && eoi_rotate) begin
            bottom_next_s = eoi_lvl_s;
        end else if (end_seq_s && cfg_aeoi && cfg_auto_rotate) begin
            bottom_next_s = ack_lvl_r;
        end else begin
            bottom_next_s = bottom_r;
        end
    end

    // INT only in IDLE, and only when the pending winner outranks everything in service.
    always_comb begin
        req_rank_s = req_lvl_s - bottom_r - LVL_W'(1'b1);
        isr_rank_s = isr_lvl_s - bottom_r - LVL_W'(1'b1);
        if (state_r == IDLE && req_valid_s) begin
            if (!isr_valid_s) begin
                int_out = 1'b1;
            end else begin
                int_out = (req_rank_s < isr_rank_s);
            end
        end else begin
            int_out = 1'b0;
        end
    end

    // Falling-edge state register; init re-initialises synchronously and overrides all events.
    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            inta_prev_r <= 1'b1;
            upm_r       <= 1'b0;
            ack_lvl_r   <= '0;
            isr_r       <= '0;
            bottom_r    <= TOP_LVL;
            clear_r     <= '0;
            data_r      <= 8'h00;
            data_en_r   <= 1'b0;
        end else if (init) begin
            state_r     <= IDLE;
            inta_prev_r <= 1'b1;
            upm_r       <= 1'b0;
            ack_lvl_r   <= '0;
            isr_r       <= '0;
            bottom_r    <= TOP_LVL;
            clear_r     <= '0;
            data_r      <= 8'h00;
            data_en_r   <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            inta_prev_r <= inta_n;
            upm_r       <= upm_next_s;
            ack_lvl_r   <= ack_next_s;
            isr_r       <= isr_next_s;
            bottom_r    <= bottom_next_s;
            clear_r     <= clear_next_s;
            data_r      <= data_next_s;
            data_en_r   <= data_en_next_s;
        end
    end

    assign isr             = isr_r;
    assign clear_req       = clear_r;
    assign priority_bottom = bottom_r;
    assign data_out        = data_r;
    // The bus driver must release the moment INTA goes high, ahead of the next clock edge.
    assign data_out_en     = data_en_r & ~inta_n;
    assign unused_s        = ^{eoi_wide_s, ack_wide_s, cfg_vec_lo[LVL_W-1:0]};

endmodule
